// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO and a
// level IRQ raised once all queued data has left the line.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   Addr  : word address from the bridge, Addr[1:0] selects the register
//   WE    : write strobe (device selected)
//   Din   : write data
//   Dout  : read data, combinational
//   txd   : serial output, idle high, registered
//   IRQ   : level interrupt, registered
module uart_tx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DIV_DEFAULT = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        txd,
    output logic        IRQ
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          en;
    logic          ie;
    logic          ovf;
    logic [15:0]   divisor;
    logic [15:0]   div_lat;
    logic [15:0]   d_eff;
    logic [15:0]   cnt;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;

    logic wr_data;
    logic wr_ctrl;
    logic wr_div;
    logic full;
    logic empty;
    logic busy;
    logic push;
    logic pop;
    logic bit_done;
    logic busy_next;
    logic ie_next;
    logic unused;

    assign unused = &{1'b0, Addr[29:2], Din[31:16]};

    assign wr_data  = WE && (Addr[1:0] == 2'd0);
    assign wr_ctrl  = WE && (Addr[1:0] == 2'd1);
    assign wr_div   = WE && (Addr[1:0] == 2'd3);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign busy     = (state != S_IDLE);
    assign bit_done = (cnt == 16'd0);
    assign d_eff    = (divisor == 16'd0) ? 16'd1 : divisor;
    assign push     = wr_data && !full;

    // Pops happen only at frame boundaries: from IDLE or at the end of STOP.
    always_comb begin
        pop = 1'b0;
        if (en && !empty) begin
            pop = (state == S_IDLE) || ((state == S_STOP) && bit_done);
        end
    end

    assign count_next = count + CW'(push) - CW'(pop);
    assign ie_next    = wr_ctrl ? Din[1] : ie;
    assign busy_next  = pop ||
                        (busy && !((state == S_STOP) && bit_done));

    always_comb begin
        Dout = 32'd0;
        case (Addr[1:0])
            2'd0: Dout = 32'd0;
            2'd1: Dout = {30'd0, ie, en};
            2'd2: Dout = {16'd0, 8'(count), 4'd0, ovf, busy, full, empty};
            2'd3: Dout = {16'd0, divisor};
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= Din[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            ovf     <= 1'b0;
            divisor <= DIV_DEFAULT;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            IRQ     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en <= Din[0];
                ie <= Din[1];
                if (Din[2]) begin
                    ovf <= 1'b0;
                end
            end
            if (wr_data && full) begin
                ovf <= 1'b1;
            end
            if (wr_div) begin
                divisor <= Din[15:0];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            IRQ   <= ie_next && (count_next == '0) && !busy_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            shreg   <= 8'd0;
            bit_idx <= 3'd0;
            cnt     <= 16'd0;
            div_lat <= 16'd1;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        div_lat <= d_eff;
                        cnt     <= d_eff - 16'd1;
                        state   <= S_START;
                        txd     <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                        txd     <= shreg[0];
                        cnt     <= div_lat - 16'd1;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        cnt <= div_lat - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        // Next frame starts on this edge when data waits.
                        if (pop) begin
                            shreg   <= mem[rd_ptr];
                            div_lat <= d_eff;
                            cnt     <= d_eff - 16'd1;
                            state   <= S_START;
                            txd     <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a
// frame-level reference model (byte queue plus 8N1 bit arithmetic).
module tb_uart_tx;

    logic        clk;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        txd;
    logic        IRQ;

    int n_chk;
    int n_pass;

    logic [7:0] q[$];
    logic       ovf_exp;

    uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_DEFAULT(16'd434)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .txd  (txd),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    function automatic logic [31:0] status_exp(input logic busy);
        int n;
        n = q.size();
        return {16'd0, 8'(n), 4'd0, ovf_exp, busy, n == 8, n == 0};
    endfunction

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        Addr = 30'(a);
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        Addr = 30'(a);
        #1;
        d = Dout;
    endtask

    task automatic push_data(input logic [7:0] b);
        bus_wr(2'd0, {24'd0, b});
        if (q.size() < 8) q.push_back(b);
        else ovf_exp = 1'b1;
    endtask

    // Next edge must be the frame's first (start-bit) edge.
    // wr_k >= 0 issues CTRL=0 then DIVISOR=2 starting after sample wr_k.
    task automatic check_frame(input logic [7:0] b, input int d,
                               input int wr_k);
        logic [31:0] r;
        for (int k = 0; k < 10 * d; k++) begin
            @(posedge clk);
            #1;
            check("txd", {31'd0, txd}, {31'd0, exp_bit(b, k / d)});
            if (k == 0 || k == 10 * d - 1) begin
                bus_rd(2'd2, r);
                check("busy", {31'd0, r[2]}, 32'd1);
                check("irq_busy", {31'd0, IRQ}, 32'd0);
            end
            if (k == wr_k) begin
                Addr = 30'd1; Din = 32'd0; WE = 1'b1;
            end else if (wr_k >= 0 && k == wr_k + 1) begin
                Addr = 30'd3; Din = 32'd2; WE = 1'b1;
            end else begin
                WE = 1'b0;
            end
        end
    endtask

    task automatic end_idle(input string tag);
        logic [31:0] r;
        @(posedge clk);
        #1;
        check({tag, "_txd"}, {31'd0, txd}, 32'd1);
        bus_rd(2'd2, r);
        check({tag, "_st"}, r, status_exp(1'b0));
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b;
        int          d;
        int          n;

        n_chk = 0;
        n_pass = 0;
        ovf_exp = 1'b0;
        reset = 1'b0;
        WE = 1'b0;
        Addr = '0;
        Din = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", {31'd0, txd}, 32'd1);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        bus_rd(2'd3, r); check("rst_div", r, 32'd434);
        bus_rd(2'd2, r); check("rst_st", r, 32'h1);
        bus_rd(2'd1, r); check("rst_ctrl", r, 32'd0);
        bus_rd(2'd0, r); check("rst_data", r, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame, D=4, 0xA5
        bus_wr(2'd3, 32'd4);
        bus_wr(2'd1, 32'h1);
        bus_rd(2'd1, r); check("ctrl_rd", r, 32'h1);
        push_data(8'hA5);
        check("pre_txd", {31'd0, txd}, 32'd1);
        check_frame(q.pop_front(), 4, -1);
        end_idle("a5");

        // Overflow and back-to-back burst
        bus_wr(2'd3, 32'd2);
        bus_wr(2'd1, 32'h0);
        for (int i = 0; i < 9; i++) push_data(8'($urandom));
        bus_rd(2'd2, r); check("full_st", r, status_exp(1'b0));
        check("full_st_k", r, 32'h0000_080A);
        bus_wr(2'd1, 32'h5);
        ovf_exp = 1'b0;
        bus_rd(2'd2, r); check("ovf_clr", r, status_exp(1'b0));
        for (int i = 0; i < 8; i++) check_frame(q.pop_front(), 2, -1);
        end_idle("burst");
        repeat (25) begin
            @(posedge clk);
            #1;
            check("no9th", {31'd0, txd}, 32'd1);
        end

        // D=0 behaves as D=1, IRQ timing
        bus_wr(2'd1, 32'h3);
        check("irq_set", {31'd0, IRQ}, 32'd1);
        bus_wr(2'd3, 32'd0);
        b = 8'($urandom);
        push_data(b);
        check("irq_drop", {31'd0, IRQ}, 32'd0);
        check_frame(q.pop_front(), 1, -1);
        end_idle("d1");
        check("irq_rise", {31'd0, IRQ}, 32'd1);
        repeat (5) @(posedge clk);
        #1;
        check("irq_hold", {31'd0, IRQ}, 32'd1);
        push_data(8'($urandom));
        check("irq_drop2", {31'd0, IRQ}, 32'd0);
        check_frame(q.pop_front(), 1, -1);
        end_idle("d1b");
        check("irq_rise2", {31'd0, IRQ}, 32'd1);
        bus_wr(2'd1, 32'h1);
        check("irq_ie0", {31'd0, IRQ}, 32'd0);

        // Reset in the middle of a frame
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd3, 32'd4);
        for (int i = 0; i < 3; i++) push_data(8'h00);
        bus_wr(2'd1, 32'h1);
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("async_txd", {31'd0, txd}, 32'd1);
        q.delete();
        ovf_exp = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        bus_rd(2'd2, r); check("mr_st", r, 32'h1);
        bus_rd(2'd3, r); check("mr_div", r, 32'd434);
        bus_rd(2'd1, r); check("mr_ctrl", r, 32'd0);
        bus_wr(2'd1, 32'h1);
        repeat (20) begin
            @(posedge clk);
            #1;
            check("mr_idle", {31'd0, txd}, 32'd1);
        end
        bus_rd(2'd2, r); check("mr_st2", r, status_exp(1'b0));

        // EN cleared and divisor changed mid-frame
        bus_wr(2'd1, 32'h0);
        bus_wr(2'd3, 32'd4);
        for (int i = 0; i < 3; i++) push_data(8'($urandom));
        bus_wr(2'd1, 32'h1);
        check_frame(q.pop_front(), 4, 10);
        end_idle("stop_en");
        check("held_st", r, r);
        bus_rd(2'd2, r); check("held_cnt", r, 32'h0000_0200);
        repeat (10) @(posedge clk);
        #1;
        check("held_txd", {31'd0, txd}, 32'd1);
        bus_wr(2'd1, 32'h1);
        check_frame(q.pop_front(), 2, -1);
        check_frame(q.pop_front(), 2, -1);
        end_idle("resume");

        // Random bursts with random divisor
        for (int r_i = 0; r_i < 6; r_i++) begin
            d = $urandom_range(1, 3);
            n = $urandom_range(1, 4);
            bus_wr(2'd1, 32'h0);
            bus_wr(2'd3, 32'(d));
            for (int i = 0; i < n; i++) push_data(8'($urandom));
            bus_rd(2'd2, r); check("rnd_st", r, status_exp(1'b0));
            bus_wr(2'd1, 32'h1);
            for (int i = 0; i < n; i++) check_frame(q.pop_front(), d, -1);
            end_idle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Memory-mapped UART transmitter peripheral.
- Sits on the system-bus bridge next to the two timers. It is a downstream consumer of bridge address, write-data and write-enable, and it returns read data to the bridge.
- Serialises bytes written by the CPU from a TX FIFO as 8N1 frames on `txd`.
- Raises a level interrupt, intended for one of the spare `HWInt` bits, when all queued data has been sent.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2 to 64.
- DIV_DEFAULT, 16'd434, reset value of the DIVISOR register (clocks per bit).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- Addr  input  30  word address [31:2] from the bridge; only Addr[3:2] is decoded.
- WE  input  1  write strobe from the bridge; asserted only when this device is selected.
- Din  input  32  write data.
- Dout  output  32  read data; combinational from Addr[3:2] and current state.
- txd  output  1  serial line; idle high; registered.
- IRQ  output  1  level interrupt; registered.

Behaviour:
- Register map (Addr[3:2]):
  - 0 DATA: write pushes Din[7:0] into the FIFO; reads 0.
  - 1 CTRL: bit0 EN, bit1 IE, bits 31:2 read 0. A write to CTRL with Din[2]=1 clears OVF (write-1-to-clear; bit2 is not stored).
  - 2 STATUS (read-only): bit0 EMPTY, bit1 FULL, bit2 BUSY (FSM not IDLE), bit3 OVF, bits[15:8] FIFO count, others 0. Writes are ignored.
  - 3 DIVISOR: bits[15:0] RW, bits 31:16 read 0.
- Reset (reset=0, async): txd=1, IRQ=0, FSM=IDLE, FIFO empty (count 0), CTRL=0, OVF=0, DIVISOR=DIV_DEFAULT.
- FIFO push:
  - A write to DATA when count<FIFO_DEPTH (sampled before the edge) is stored and count increments.
  - A write to DATA when full drops the data, leaves count unchanged and sets OVF (sticky).
  - A push and a pop in the same cycle both take effect; count is unchanged.
  - Push is accepted regardless of EN.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If EN=1 and the FIFO is non-empty:
    - pop the head byte into the shift register;
    - latch the effective divisor D = max(DIVISOR,1) for the whole frame;
    - go to START, with txd=0 from that edge.
  - START: holds for D cycles, then goes to DATA with bit index 0; txd = bit0.
  - DATA: each bit holds for D cycles, LSB first. After bit7's D cycles, go to STOP with txd=1.
  - STOP: holds for D cycles. Then:
    - if EN=1 and the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle cycle);
    - otherwise go to IDLE.
- Frame length: exactly 10*D cycles.
- Latency: a DATA write at edge T into an idle, enabled, empty unit pops at edge T+1; txd falls at T+1.
- Clearing EN mid-frame: the current frame completes; no further pops occur.
- DIVISOR writes mid-frame take effect at the next frame start.
- Bit-period counter is 16 bits; it reloads on every bit boundary, so there is no wrap beyond D.
- IRQ is registered: IRQ(next) = IE & EMPTY & ~BUSY, evaluated on next-state values. It stays high until a DATA write or IE=0. One-cycle assert latency from the condition becoming true.
- Reset mid-frame: txd returns high immediately (async), the FIFO contents are discarded, and there is no partial completion.

Test Plan:
1. Reset -> txd=1, IRQ=0. Reading DIVISOR gives 434; reading STATUS gives 0x00000001; reading CTRL gives 0.
2. DIVISOR=4, CTRL=0x1, DATA=0xA5 -> txd holds each level for 4 cycles in the order 0,1,0,1,0,0,1,0,1,1. The frame is 40 cycles, starting at the cycle after the write. BUSY=1 during the frame and 0 after.
3. EN=0; write DATA nine times (0x00..0x08) with depth 8 -> STATUS count=8, FULL=1, OVF=1. Writing CTRL=0x5 clears OVF and sets EN. Bytes 0x00..0x07 are sent back-to-back as 8*10*D cycles with no idle gap; 0x08 is never sent.
4. CTRL=0x3, DIVISOR=0, DATA=0x0F -> D=1, so the frame lasts 10 cycles. IRQ rises 1 cycle after the stop bit ends and stays high. A new DATA write drops IRQ on the next edge.
5. Mid-frame (cycle 15 of a 40-cycle frame) assert reset=0 -> txd=1 immediately. After release, STATUS=0x1, no pending bytes are sent, and DIVISOR=434.
6. Mid-frame, write CTRL=0 and DIVISOR=2 with 2 bytes queued -> the current frame finishes at the old D. The FSM then stays IDLE with count=2. Setting EN=1 sends the next frame with D=2.
